pmu_ctrl: RTL

- AON-domain power-sequencing controller; the digital master side of the PMU analog interface.
- Drives DC-DC enable, oscillator enables and RC frequency code, and brownout thresholds.
- Consumes dcdc_ready, vwarn and BOR event; clears BOR with a 4-phase handshake and generates the SW PoR pulse.
- Sequences OFF -> ramp -> clocks -> ACTIVE and back, with timeout and brownout recovery.

---
 rtl/pmu_ctrl_pkg.sv | 24 ++
 rtl/pmu_sync.sv | 26 ++
 rtl/pmu_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmu_ctrl_pkg.sv
// Shared types and constants for the AON power-sequencing controller.
// State encodings are fixed because pwr_state is exported to software.
package pmu_ctrl_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic [7:0] DEF_VTH1    = 8'd180;
    localparam logic [7:0] DEF_VTH2    = 8'd150;
    localparam logic [2:0] DEF_RC_FREQ = 3'b010;

    typedef enum logic [2:0] {
        PwrOff        = 3'd0,
        PwrRampUp     = 3'd1,
        PwrClkEn      = 3'd2,
        PwrActive     = 3'd3,
        PwrRampDown   = 3'd4,
        PwrBorRecover = 3'd5
    } pwr_state_t;

    function automatic logic [7:0] vth_min(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/pmu_sync.sv
// Two-flop synchronizer for asynchronous PMU status inputs.
module pmu_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pmu_ctrl.sv
// PMU power-sequencing controller: OFF -> RAMP_UP -> CLK_EN -> ACTIVE and back, with BOR recovery.
// Build option PMU_CTRL_BOR_AUTO_RESTART_EN: restart the ramp directly after BOR recovery.
module pmu_ctrl
    import pmu_ctrl_pkg::*;
#(
    parameter int unsigned DCDC_TIMEOUT = 64,
    parameter int unsigned XTAL_SETTLE  = 16,
    parameter int unsigned RST_HOLD     = 4,
    parameter logic [7:0]  V_TH1_DEF    = DEF_VTH1,
    parameter logic [7:0]  V_TH2_DEF    = DEF_VTH2,
    parameter logic [2:0]  RC_FREQ_DEF  = DEF_RC_FREQ
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pwr_on_req,
    input  logic       i_pwr_off_req,
    input  logic       i_cfg_xtal_en,
    input  logic [2:0] i_cfg_rc_freq,
    input  logic       i_cfg_vth_wr,
    input  logic [7:0] i_cfg_vth1,
    input  logic [7:0] i_cfg_vth2,
    input  logic       i_cfg_sw_por,
    input  logic       i_pmu_dcdc_ready,
    input  logic       i_pmu_vwarn,
    input  logic       i_bor_event_int,
    output logic       o_pmu_dcdc_en,
    output logic       o_clk_32k_xtal_en,
    output logic       o_clk_rc_prog_en,
    output logic [2:0] o_clk_rc_prog_freq,
    output logic [7:0] o_v_th1_cfg,
    output logic [7:0] o_v_th2_cfg,
    output logic       o_bor_event_int_clr,
    output logic       o_soc_por_sw_ctrl,
    output logic       o_soc_active,
    output logic [2:0] o_pwr_state,
    output logic       o_err_timeout,
    output logic [7:0] o_bor_cnt,
    output logic       o_vwarn_irq
);

    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(DCDC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(XTAL_SETTLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);
    localparam logic [7:0]       BOR_MAX     = 8'hFF;

    logic w_ready;
    logic w_vwarn;
    logic w_bor;

    pmu_sync #(.WIDTH(1)) u_sync_ready (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_pmu_dcdc_ready),
        .o_q   (w_ready)
    );

    pmu_sync #(.WIDTH(1)) u_sync_vwarn (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_pmu_vwarn),
        .o_q   (w_vwarn)
    );

    pmu_sync #(.WIDTH(1)) u_sync_bor (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_bor_event_int),
        .o_q   (w_bor)
    );

    pwr_state_t       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_dcdc_en, w_dcdc_en_d;
    logic             r_xtal_en, w_xtal_en_d;
    logic             r_rc_en, w_rc_en_d;
    logic [2:0]       r_freq, w_freq_d;
    logic             r_clr, w_clr_d;
    logic             r_err, w_err_d;
    logic [7:0]       r_bor_cnt, w_bor_cnt_d;
    logic             r_bor_prev;
    logic             r_vwarn_prev;
    logic             r_vwarn_irq;
    logic [7:0]       r_vth1, r_vth2;
    logic             r_sw_ctrl;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_bor_rise;
    logic             w_bor_hit;

    assign w_bor_rise = w_bor & ~r_bor_prev;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_dcdc_en_d = r_dcdc_en;
        w_xtal_en_d = r_xtal_en;
        w_rc_en_d   = r_rc_en;
        w_freq_d    = r_freq;
        w_clr_d     = r_clr;
        w_err_d     = r_err;
        w_bor_cnt_d = r_bor_cnt;
        w_bor_hit   = 1'b0;

        case (r_state)
            PwrOff: begin
                if (i_pwr_on_req) begin
                    w_state_d   = PwrRampUp;
                    w_dcdc_en_d = 1'b1;
                    w_cnt_d     = '0;
                end
            end
            PwrRampUp: begin
                if (w_bor_rise) begin
                    w_bor_hit = 1'b1;
                end else if (w_ready) begin
                    w_state_d   = PwrClkEn;
                    w_cnt_d     = '0;
                    w_rc_en_d   = 1'b1;
                    w_xtal_en_d = i_cfg_xtal_en;
                    w_freq_d    = i_cfg_rc_freq;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_d   = PwrRampDown;
                    w_err_d     = 1'b1;
                    w_dcdc_en_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            PwrClkEn: begin
                if (w_bor_rise) begin
                    w_bor_hit = 1'b1;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_d = PwrActive;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            PwrActive: begin
                // Loss of DC-DC ready without a requested power-down is a brownout.
                if (w_bor_rise) begin
                    w_bor_hit = 1'b1;
                end else if (i_pwr_off_req) begin
                    w_state_d   = PwrRampDown;
                    w_dcdc_en_d = 1'b0;
                    w_rc_en_d   = 1'b0;
                    w_xtal_en_d = 1'b0;
                end else if (!w_ready) begin
                    w_bor_hit = 1'b1;
                end
            end
            PwrRampDown: begin
                if (!w_ready) begin
                    w_state_d = PwrOff;
                end
            end
            PwrBorRecover: begin
                if (r_clr) begin
                    if (!w_bor) begin
                        w_clr_d = 1'b0;
                    end
                end else if (!w_ready) begin
`ifdef PMU_CTRL_BOR_AUTO_RESTART_EN
                    if (r_bor_cnt != BOR_MAX) begin
                        w_state_d   = PwrRampUp;
                        w_dcdc_en_d = 1'b1;
                        w_cnt_d     = '0;
                    end else begin
                        w_state_d = PwrOff;
                    end
`else
                    w_state_d = PwrOff;
`endif
                end
            end
            default: begin
                w_state_d   = PwrOff;
                w_dcdc_en_d = 1'b0;
                w_rc_en_d   = 1'b0;
                w_xtal_en_d = 1'b0;
                w_clr_d     = 1'b0;
            end
        endcase

        if (w_bor_hit) begin
            w_state_d   = PwrBorRecover;
            w_dcdc_en_d = 1'b0;
            w_rc_en_d   = 1'b0;
            w_xtal_en_d = 1'b0;
            w_clr_d     = 1'b1;
            if (r_bor_cnt != BOR_MAX) begin
                w_bor_cnt_d = r_bor_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PwrOff;
            r_cnt        <= '0;
            r_dcdc_en    <= 1'b0;
            r_xtal_en    <= 1'b0;
            r_rc_en      <= 1'b0;
            r_freq       <= RC_FREQ_DEF;
            r_clr        <= 1'b0;
            r_err        <= 1'b0;
            r_bor_cnt    <= '0;
            r_bor_prev   <= 1'b0;
            r_vwarn_prev <= 1'b0;
            r_vwarn_irq  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_dcdc_en    <= w_dcdc_en_d;
            r_xtal_en    <= w_xtal_en_d;
            r_rc_en      <= w_rc_en_d;
            r_freq       <= w_freq_d;
            r_clr        <= w_clr_d;
            r_err        <= w_err_d;
            r_bor_cnt    <= w_bor_cnt_d;
            r_bor_prev   <= w_bor;
            r_vwarn_prev <= w_vwarn;
            r_vwarn_irq  <= (r_state == PwrActive) & w_vwarn & ~r_vwarn_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vth1 <= V_TH1_DEF;
            r_vth2 <= V_TH2_DEF;
        end else if (i_cfg_vth_wr) begin
            r_vth1 <= i_cfg_vth1;
            r_vth2 <= vth_min(i_cfg_vth2, i_cfg_vth1);
        end
    end

    // Hold counter runs only while staying in ACTIVE; any exit aborts the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_ctrl  <= 1'b0;
            r_hold_cnt <= '0;
        end else if (r_state != PwrActive || w_state_d != PwrActive) begin
            r_sw_ctrl  <= 1'b0;
            r_hold_cnt <= '0;
        end else if (r_sw_ctrl) begin
            if (r_hold_cnt == '0) begin
                r_sw_ctrl <= 1'b0;
            end else begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end
        end else if (i_cfg_sw_por) begin
            r_sw_ctrl  <= 1'b1;
            r_hold_cnt <= HOLD_LAST;
        end
    end

    assign o_pmu_dcdc_en       = r_dcdc_en;
    assign o_clk_32k_xtal_en   = r_xtal_en;
    assign o_clk_rc_prog_en    = r_rc_en;
    assign o_clk_rc_prog_freq  = r_freq;
    assign o_v_th1_cfg         = r_vth1;
    assign o_v_th2_cfg         = r_vth2;
    assign o_bor_event_int_clr = r_clr;
    assign o_soc_por_sw_ctrl   = r_sw_ctrl;
    assign o_soc_active        = (r_state == PwrActive);
    assign o_pwr_state         = r_state;
    assign o_err_timeout       = r_err;
    assign o_bor_cnt           = r_bor_cnt;
    assign o_vwarn_irq         = r_vwarn_irq;

endmodule
